// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel-tick enable in, counters, syncs, data enable and markers out.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 10
);
    logic          en;
    logic [CW-1:0] xpos;
    logic [CW-1:0] ypos;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  en,
        output xpos, ypos, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        output en,
        input  xpos, ypos, hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: x/y counters, registered sync/de/marker decode
// followed by an en-qualified delay line to align with downstream pixel pipelines.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CW       = 10,
    parameter int unsigned DELAY    = 0
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0) || (DELAY > 15)) begin : g_bad_params
        $error("vga_timing_gen: mode totals do not fit in CW bits, or DELAY > 15");
    end

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic line_start;
        logic frame_start;
    } dec_t;

    localparam dec_t DEC_IDLE = '{
        hsync:       ~H_POL,
        vsync:       ~V_POL,
        de:          1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    logic [CW-1:0] xpos_q;
    logic [CW-1:0] ypos_q;
    dec_t          dec_c;
    dec_t          pipe_q [DELAY+1];

    // Pixel/line counters; both wrap together at the last pixel of the last line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xpos_q <= '0;
            ypos_q <= '0;
        end else if (bus.en) begin
            if (xpos_q == CW'(H_TOTAL - 1)) begin
                xpos_q <= '0;
                if (ypos_q == CW'(V_TOTAL - 1)) begin
                    ypos_q <= '0;
                end else begin
                    ypos_q <= ypos_q + CW'(1);
                end
            end else begin
                xpos_q <= xpos_q + CW'(1);
            end
        end
    end

    // Decode of the current position, compared in 32 bits so region ends may equal 2**CW.
    always_comb begin
        logic [31:0] x;
        logic [31:0] y;
        x = 32'(xpos_q);
        y = 32'(ypos_q);
        dec_c             = DEC_IDLE;
        dec_c.de          = (x < H_ACTIVE) && (y < V_ACTIVE);
        dec_c.hsync       = ((x >= HS_START) && (x < HS_END)) ? H_POL : ~H_POL;
        dec_c.vsync       = ((y >= VS_START) && (y < VS_END)) ? V_POL : ~V_POL;
        dec_c.line_start  = (x == 32'd0);
        dec_c.frame_start = (x == 32'd0) && (y == 32'd0);
    end

    // Stage 0 registers the decode; stages 1..DELAY realign it. Reset flushes every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= int'(DELAY); i++) begin
                pipe_q[i] <= DEC_IDLE;
            end
        end else if (bus.en) begin
            pipe_q[0] <= dec_c;
            for (int i = 1; i <= int'(DELAY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.xpos        = xpos_q;
    assign bus.ypos        = ypos_q;
    assign bus.hsync       = pipe_q[DELAY].hsync;
    assign bus.vsync       = pipe_q[DELAY].vsync;
    assign bus.de          = pipe_q[DELAY].de;
    assign bus.line_start  = pipe_q[DELAY].line_start;
    assign bus.frame_start = pipe_q[DELAY].frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes driven by a shared en/rst, checked against a
// tick-count reference model of the raster.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    int    checks = 0;
    int    errors = 0;
    longint ticks = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(5))  bus_a ();
    vga_timing_gen_if #(.CW(4))  bus_b ();
    vga_timing_gen_if #(.CW(10)) bus_d ();

    assign bus_a.en = en;
    assign bus_b.en = en;
    assign bus_d.en = en;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .CW(5), .DELAY(0)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CW(4), .DELAY(3)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    vga_timing_gen dut_d (.clk(clk), .rst(rst), .bus(bus_d));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at tick %0d: got %0h expected %0h", tag, ticks, got, exp);
        end
    endtask

    // Expected {hsync,vsync,de,line_start,frame_start} after t en-ticks since reset.
    function automatic logic [4:0] ref_out(input longint t, input int ha, hf, hs, hb,
                                           input int va, vf, vs, vb, input int d,
                                           input bit hp, vp);
        longint ht, vt, k, x, y;
        logic h, v, e, ls, fs;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (t < 1 + d) return {~hp, ~vp, 3'b000};
        k  = t - 1 - d;
        x  = k % ht;
        y  = (k / ht) % vt;
        h  = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
        v  = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
        e  = (x < ha) && (y < va);
        ls = (x == 0);
        fs = (x == 0) && (y == 0);
        return {h, v, e, ls, fs};
    endfunction

    task automatic check_dut(input string n, input logic [31:0] x, input logic [31:0] y,
                             input logic [4:0] o, input int ha, hf, hs, hb,
                             input int va, vf, vs, vb, input int d, input bit hp, vp);
        longint ht, vt;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        check({n, " xpos"}, x, 32'(ticks % ht));
        check({n, " ypos"}, y, 32'((ticks / ht) % vt));
        check({n, " hs/vs/de/ls/fs"}, 32'(o),
              32'(ref_out(ticks, ha, hf, hs, hb, va, vf, vs, vb, d, hp, vp)));
    endtask

    task automatic check_all();
        check_dut("a", 32'(bus_a.xpos), 32'(bus_a.ypos),
                  {bus_a.hsync, bus_a.vsync, bus_a.de, bus_a.line_start, bus_a.frame_start},
                  8, 2, 3, 3, 4, 1, 2, 1, 0, 1'b0, 1'b0);
        check_dut("b", 32'(bus_b.xpos), 32'(bus_b.ypos),
                  {bus_b.hsync, bus_b.vsync, bus_b.de, bus_b.line_start, bus_b.frame_start},
                  8, 2, 3, 3, 4, 1, 2, 1, 3, 1'b1, 1'b1);
        check_dut("d", 32'(bus_d.xpos), 32'(bus_d.ypos),
                  {bus_d.hsync, bus_d.vsync, bus_d.de, bus_d.line_start, bus_d.frame_start},
                  640, 16, 96, 48, 480, 10, 2, 33, 0, 1'b0, 1'b0);
    endtask

    // One clock: drive en at the falling edge, count the tick, check at the next falling edge.
    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        if (en && !rst) ticks++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        @(negedge clk);
        check_all();
        step(1'b1);
        step(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) step(1'b1);
        for (int i = 0; i < 300; i++) step(1'(i % 2 == 0));
        for (int i = 0; i < 1500; i++) step(1'(($urandom % 10) < 7));

        // Run to ypos=5, xpos=12 of the small mode, then reset asynchronously mid-cycle.
        for (int i = 0; i < 200 && (ticks % 128) != 92; i++) step(1'b1);
        check("reach y5 x12", 32'(ticks % 128), 32'd92);
        #2 rst = 1'b1;
        #1;
        ticks = 0;
        check_all();
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 600; i++) step(1'(($urandom % 10) < 6));
        for (int i = 0; i < 200; i++) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
